// File: rtl/count_sampler_pkg.sv
// count_sampler_pkg: shared types and constants for the count sampler.
//   COUNT_W         - width of the sampled upstream counter
//   DEFAULT_PERIOD  - default number of enabled cycles between samples
//   DEFAULT_DEPTH   - default sample FIFO depth
//   sample_t        - one FIFO entry: wrap flag plus captured count
package count_sampler_pkg;

  localparam int unsigned COUNT_W        = 8;
  localparam int unsigned DEFAULT_PERIOD = 16;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  typedef struct packed {
    logic               wrap;
    logic [COUNT_W-1:0] count;
  } sample_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO of sample_t entries.
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-high reset; empties the FIFO
//   i_push   - write i_data (accepted when not full, or when full and popping)
//   i_data   - entry to write
//   i_pop    - remove head (ignored when empty)
//   o_data   - head entry, zero while empty
//   o_full   - occupancy == DEPTH
//   o_empty  - occupancy == 0
module sample_fifo
  import count_sampler_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  sample_t i_data,
  input  logic    i_pop,
  output sample_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  sample_t          r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Storage is not reset; masking keeps the head at zero whenever nothing is queued.
  always_comb begin
    o_data = '0;
    if (!o_empty) o_data = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/count_sampler.sv
// count_sampler: periodically samples an upstream 8-bit counter, flags 255->0 wraps
// seen since the previous sample, and queues {wrap, count} entries in a FIFO.
//   clk            - clock, rising edge
//   reset          - asynchronous active-high reset
//   count_in       - upstream counter value
//   enable         - period timer runs and samples are taken while high
//   clear_overflow - pulse clearing the sticky overflow flag
//   sample_data    - count of the FIFO head
//   sample_wrap    - wrap flag of the FIFO head
//   sample_valid   - FIFO non-empty
//   sample_ready   - consumer accepts the head when high with sample_valid
//   overflow       - sticky; a sample was dropped on a full FIFO
module count_sampler
  import count_sampler_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               enable,
  input  logic               clear_overflow,
  output logic [COUNT_W-1:0] sample_data,
  output logic               sample_wrap,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overflow
);

  localparam int unsigned TIMER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(PERIOD - 1);

  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_d;
  logic [COUNT_W-1:0] r_prev_count;
  logic               r_wrap_acc;
  logic               w_wrap_acc_d;
  logic               r_overflow;
  logic               w_overflow_d;

  logic    w_sample;
  logic    w_wrap_now;
  sample_t w_push_data;
  sample_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_pop;
  logic    w_drop;

  assign w_sample   = enable && (r_timer == TIMER_MAX);
  // A smaller value than last cycle means the upstream counter rolled over.
  assign w_wrap_now = (count_in < r_prev_count);

  // A wrap seen in the sampling cycle itself belongs to this sample.
  assign w_push_data = '{wrap: r_wrap_acc | w_wrap_now, count: count_in};

  assign w_pop  = sample_valid && sample_ready;
  assign w_drop = w_sample && w_full && !w_pop;

  always_comb begin
    w_timer_d = r_timer;
    if (enable) begin
      w_timer_d = (r_timer == TIMER_MAX) ? '0 : r_timer + TIMER_W'(1);
    end

    w_wrap_acc_d = r_wrap_acc;
    if (w_sample)        w_wrap_acc_d = 1'b0;
    else if (w_wrap_now) w_wrap_acc_d = 1'b1;

    // A fresh drop wins over a simultaneous clear.
    w_overflow_d = r_overflow;
    if (w_drop)              w_overflow_d = 1'b1;
    else if (clear_overflow) w_overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer      <= '0;
      r_prev_count <= '0;
      r_wrap_acc   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_timer      <= w_timer_d;
      r_prev_count <= count_in;
      r_wrap_acc   <= w_wrap_acc_d;
      r_overflow   <= w_overflow_d;
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_sample),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign sample_valid = !w_empty;
  assign sample_data  = w_head.count;
  assign sample_wrap  = w_head.wrap;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_count_sampler.sv
module tb_count_sampler;

  localparam int P = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] count_in = '0;
  logic       enable = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] sample_data;
  logic       sample_wrap;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard and reference state.
  logic [8:0] sb[$];
  int         m_timer = 0;
  logic [7:0] m_prev = '0;
  logic       m_wrap = 1'b0;
  logic       m_ovf = 1'b0;

  count_sampler #(
    .PERIOD (P),
    .DEPTH  (D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .count_in       (count_in),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .sample_data    (sample_data),
    .sample_wrap    (sample_wrap),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Monitor at the falling edge: inputs are driven 2 time units after the rising edge.
  always @(negedge clk) begin
    logic [8:0] exp_e;
    logic       drop;
    drop = 1'b0;
    if (reset) begin
      sb.delete();
      m_timer = 0;
      m_prev  = '0;
      m_wrap  = 1'b0;
      m_ovf   = 1'b0;
      n_vec++;
      if (sample_valid !== 1'b0 || overflow !== 1'b0 || sample_data !== 8'd0 ||
          sample_wrap !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got valid=%b ovf=%b data=%0d wrap=%b, want all 0",
                 sample_valid, overflow, sample_data, sample_wrap);
      end
    end else begin
      n_vec++;
      if (sample_valid !== (sb.size() != 0)) begin
        n_err++;
        $display("FAIL valid: got %b want %b at %0t", sample_valid, sb.size() != 0, $time);
      end
      n_vec++;
      if (overflow !== m_ovf) begin
        n_err++;
        $display("FAIL overflow: got %b want %b at %0t", overflow, m_ovf, $time);
      end
      if (sample_ready && sb.size() > 0) begin
        exp_e = sb.pop_front();
        n_vec++;
        if ({sample_wrap, sample_data} !== exp_e) begin
          n_err++;
          $display("FAIL pop_entry: got wrap=%b data=%0d want wrap=%b data=%0d at %0t",
                   sample_wrap, sample_data, exp_e[8], exp_e[7:0], $time);
        end
      end
      if (enable && m_timer == P - 1) begin
        exp_e = {m_wrap | (count_in < m_prev), count_in};
        if (sb.size() < D) sb.push_back(exp_e);
        else drop = 1'b1;
        m_wrap = 1'b0;
      end else if (count_in < m_prev) begin
        m_wrap = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      m_prev = count_in;
      if (enable) m_timer = (m_timer + 1) % P;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    sample_ready = 1'b0;
    clear_overflow = 1'b0;
    count_in = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    n_vec++;
    if (sample_valid !== 1'b0 || overflow !== 1'b0 || sample_data !== 8'd0) begin
      n_err++;
      $display("FAIL test_reset: got valid=%b ovf=%b data=%0d want 0/0/0",
               sample_valid, overflow, sample_data);
    end
    do_reset();
  endtask

  task automatic test_ramp();
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      count_in = 8'(k);
      cycle();
      n_vec++;
      if (k % 4 == 3) begin
        if (sample_valid !== 1'b1 || sample_data !== 8'(k) || sample_wrap !== 1'b0) begin
          n_err++;
          $display("FAIL ramp_sample: got valid=%b data=%0d wrap=%b want 1/%0d/0",
                   sample_valid, sample_data, sample_wrap, k);
        end
      end else if (sample_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ramp_idle: got valid=%b want 0 at k=%0d", sample_valid, k);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] vals [8];
    vals = '{8'd250, 8'd252, 8'd254, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      count_in = vals[i];
      cycle();
      if (i == 3) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample_data !== 8'd1 || sample_wrap !== 1'b1) begin
          n_err++;
          $display("FAIL wrap_set: got valid=%b data=%0d wrap=%b want 1/1/1",
                   sample_valid, sample_data, sample_wrap);
        end
      end
      if (i == 7) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample_data !== 8'd5 || sample_wrap !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_clear: got valid=%b data=%0d wrap=%b want 1/5/0",
                   sample_valid, sample_data, sample_wrap);
        end
      end
    end
  endtask

  task automatic test_overflow_clear();
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      count_in = 8'(k);
      cycle();
      if (k == 15) begin
        n_vec++;
        if (overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_full_no_drop: got %b want 0", overflow);
        end
      end
    end
    n_vec++;
    if (overflow !== 1'b1 || sample_data !== 8'd3) begin
      n_err++;
      $display("FAIL ovf_drop: got ovf=%b head=%0d want 1/3", overflow, sample_data);
    end
    enable = 1'b0;
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    enable = 1'b1;
    for (int k = 20; k < 24; k++) begin
      count_in = 8'(k);
      clear_overflow = (k == 23);
      cycle();
    end
    clear_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_clear_vs_drop: got %b want 1", overflow);
    end
    enable = 1'b0;
    sample_ready = 1'b1;
    repeat (6) cycle();
    n_vec++;
    if (sample_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drain: got valid=%b ovf=%b want 0/1", sample_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b0;
    for (int k = 0; k < 19; k++) begin
      count_in = 8'(k);
      cycle();
    end
    count_in = 8'd19;
    sample_ready = 1'b1;
    cycle();
    sample_ready = 1'b0;
    n_vec++;
    if (overflow !== 1'b0 || sample_valid !== 1'b1 || sample_data !== 8'd7) begin
      n_err++;
      $display("FAIL full_push_pop: got ovf=%b valid=%b head=%0d want 0/1/7",
               overflow, sample_valid, sample_data);
    end
    enable = 1'b0;
    sample_ready = 1'b1;
    n = 0;
    repeat (6) begin
      if (sample_valid) n++;
      cycle();
    end
    n_vec++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL full_occupancy: got %0d entries want 4", n);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      count_in = 8'(k);
      cycle();
    end
    n_vec++;
    if (sample_valid !== 1'b1 || sample_data !== 8'd3) begin
      n_err++;
      $display("FAIL mid_queued: got valid=%b head=%0d want 1/3", sample_valid, sample_data);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (sample_valid !== 1'b0 || sample_data !== 8'd0) begin
      n_err++;
      $display("FAIL mid_async_reset: got valid=%b data=%0d want 0/0",
               sample_valid, sample_data);
    end
    cycle();
    reset = 1'b0;
    sample_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      count_in = 8'(100 + k);
      cycle();
      n_vec++;
      if (sample_valid !== (k == 3) || (k == 3 && sample_data !== 8'd103)) begin
        n_err++;
        $display("FAIL mid_first_sample: got valid=%b data=%0d at k=%0d want valid=%b data=103",
                 sample_valid, sample_data, k, k == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_overflow_clear();
    test_back_to_back();
    test_reset_mid();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
